// File: rtl/timer_ip.sv
// timer_ip: memory-mapped down-counting timer with prescaler, auto-reload and sticky expiry interrupt
module timer_ip #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wd,
    input  logic [31:0]           address,
    input  logic                  we,
    output logic [DATA_WIDTH-1:0] rd,
    output logic                  irq
);
    logic [2:0]            off;
    logic                  en, auto_rl, irq_en, expired;
    logic [DATA_WIDTH-1:0] load, count;
    logic [15:0]           prescale, pcnt;
    logic                  wr_ctrl, wr_load, wr_count, wr_pre, wr_stat;
    logic                  tick, expire, rise, stop;
    logic                  addr_unused;

    assign off         = address[4:2];
    assign addr_unused = ^{address[31:5], address[1:0]};
    assign wr_ctrl     = we && off == 3'd0;
    assign wr_load     = we && off == 3'd1;
    assign wr_count    = we && off == 3'd2;
    assign wr_pre      = we && off == 3'd3;
    assign wr_stat     = we && off == 3'd4;
    assign tick        = en && !wr_pre && pcnt == prescale;
    assign expire      = tick && count == '0;
    assign rise        = wr_ctrl && wd[0] && !en;
    assign stop        = wr_ctrl && !wd[0];
    assign irq         = expired && irq_en;

    assign rd = off == 3'd0 ? DATA_WIDTH'({irq_en, auto_rl, en}) :
                off == 3'd1 ? load :
                off == 3'd2 ? count :
                off == 3'd3 ? DATA_WIDTH'(prescale) :
                off == 3'd4 ? DATA_WIDTH'(expired) : '0;

    // Control bits, reload/prescale registers and the sticky expiry flag (set beats clear)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en       <= 1'b0;
            auto_rl  <= 1'b0;
            irq_en   <= 1'b0;
            expired  <= 1'b0;
            load     <= '0;
            prescale <= '0;
        end else begin
            if (wr_ctrl) {irq_en, auto_rl, en} <= wd[2:0];
            else if (expire && !auto_rl) en <= 1'b0;
            if (wr_load) load <= wd;
            if (wr_pre) prescale <= wd[15:0];
            if (expire) expired <= 1'b1;
            else if (wr_stat && wd[0]) expired <= 1'b0;
        end
    end

    // Counter: direct write beats enable/expiry reload, which beats the tick decrement
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count <= '0;
        else if (wr_count) count <= wd;
        else if (rise || (expire && auto_rl && !stop)) count <= load;
        else if (tick && count != '0) count <= count - DATA_WIDTH'(1);
    end

    // Prescaler phase: held at 0 while idle, restarted by a PRESCALE write, wraps at PRESCALE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pcnt <= '0;
        else pcnt <= (!en || wr_pre || pcnt == prescale) ? '0 : pcnt + 16'd1;
    end
endmodule
